clct_sort_seq_cclut: RTL and testbench

//  Serial scheduler for the ccLUT best-CLCT sort: one shared comparator scans 7 CFEB key-groups, one group per clock.
//  On start it steps grp_sel 0..6 and keeps a running best. It then applies the ccLUT key/offset correction and

---
 rtl/clct_sort_seq_cclut_if.sv | 50 +++++
 rtl/clct_sort_seq_cclut.sv | 227 ++++++++++++++++++++++
 tb/tb_clct_sort_seq_cclut.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/clct_sort_seq_cclut_if.sv
// Bus between the ccLUT serial sorter and its neighbours.
// Carries the start/enable controls, the muxed per-group inputs selected by
// grp_sel, and the registered best-CLCT result with busy/done status.
//   master : driver of start, grp_en, pat_thresh and the grp_* inputs
//   slave  : the sorter, which drives grp_sel, busy, done and best_*
interface clct_sort_seq_cclut_if #(
  parameter int unsigned NGRP    = 7,
  parameter int unsigned MXPATB  = 7,
  parameter int unsigned MXKEYB  = 5,
  parameter int unsigned MXKEYBX = 8,
  parameter int unsigned MXOFFSB = 4,
  parameter int unsigned MXQLTB  = 9,
  parameter int unsigned MXBNDB  = 5,
  parameter int unsigned MXPATC  = 12,
  parameter int unsigned MXXKYB  = 10
);
  logic                start;
  logic [NGRP-1:0]     grp_en;
  logic [MXPATB-1:0]   pat_thresh;
  logic [2:0]          grp_sel;
  logic [MXPATB-1:0]   grp_pat;
  logic [MXKEYB-1:0]   grp_key;
  logic [MXOFFSB-1:0]  grp_offs;
  logic [MXQLTB-1:0]   grp_qlt;
  logic [MXBNDB-1:0]   grp_bend;
  logic [MXPATC-1:0]   grp_carry;
  logic                busy;
  logic                done;
  logic                best_vld;
  logic [MXPATB-1:0]   best_pat;
  logic [MXQLTB-1:0]   best_qlt;
  logic [MXBNDB-1:0]   best_bend;
  logic [MXPATC-1:0]   best_carry;
  logic [MXKEYBX-1:0]  best_key;
  logic [MXXKYB-1:0]   best_subkey;

  modport master (
    output start, grp_en, pat_thresh,
    output grp_pat, grp_key, grp_offs, grp_qlt, grp_bend, grp_carry,
    input  grp_sel, busy, done,
    input  best_vld, best_pat, best_qlt, best_bend, best_carry, best_key, best_subkey
  );

  modport slave (
    input  start, grp_en, pat_thresh,
    input  grp_pat, grp_key, grp_offs, grp_qlt, grp_bend, grp_carry,
    output grp_sel, busy, done,
    output best_vld, best_pat, best_qlt, best_bend, best_carry, best_key, best_subkey
  );
endinterface

// File: rtl/clct_sort_seq_cclut.sv
// Serial ccLUT best-CLCT sorter: one shared comparator scans the 7 CFEB
// key-groups one per clock, keeps a running best, then applies the ccLUT
// key/offset correction and presents one registered best CLCT.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : start/grp_en/pat_thresh in, grp_sel out (external input mux),
//                  grp_pat/key/offs/qlt/bend/carry in, busy/done/best_* out
// Build option: define CCLUT_SORT_QLT_EN to sort on {grp_pat, grp_qlt} so that
// quality breaks pattern ties; otherwise the sort key is grp_pat alone.
// Timing: start edge E0, groups sampled on E1..E7, outputs and done after E8.
module clct_sort_seq_cclut (
  input  logic                  clock,
  input  logic                  reset,
  clct_sort_seq_cclut_if.slave  bus
);

  localparam int unsigned NGRP    = 7;
  localparam int unsigned MXPATB  = 7;
  localparam int unsigned MXKEYB  = 5;
  localparam int unsigned MXKEYBX = 8;
  localparam int unsigned MXOFFSB = 4;
  localparam int unsigned MXQLTB  = 9;
  localparam int unsigned MXBNDB  = 5;
  localparam int unsigned MXPATC  = 12;
  localparam int unsigned MXXKYB  = 10;
  localparam logic [2:0]  LAST_GRP = 3'(NGRP - 1);

`ifdef CCLUT_SORT_QLT_EN
  localparam int unsigned SORTB = MXPATB + MXQLTB;
`else
  localparam int unsigned SORTB = MXPATB;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CALC, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          grp_sel_q, grp_sel_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;

  // running best candidate
  logic [MXPATB-1:0]   run_pat_q,   run_pat_nxt;
  logic [2:0]          run_grp_q,   run_grp_nxt;
  logic [MXKEYB-1:0]   run_key_q,   run_key_nxt;
  logic [MXOFFSB-1:0]  run_offs_q,  run_offs_nxt;
  logic [MXQLTB-1:0]   run_qlt_q,   run_qlt_nxt;
  logic [MXBNDB-1:0]   run_bend_q,  run_bend_nxt;
  logic [MXPATC-1:0]   run_carry_q, run_carry_nxt;

  // registered result
  logic                best_vld_q,    best_vld_nxt;
  logic [MXPATB-1:0]   best_pat_q,    best_pat_nxt;
  logic [MXQLTB-1:0]   best_qlt_q,    best_qlt_nxt;
  logic [MXBNDB-1:0]   best_bend_q,   best_bend_nxt;
  logic [MXPATC-1:0]   best_carry_q,  best_carry_nxt;
  logic [MXKEYBX-1:0]  best_key_q,    best_key_nxt;
  logic [MXXKYB-1:0]   best_subkey_q, best_subkey_nxt;

  logic [7:0]          en_pad;
  logic                grp_en_cur;
  logic [SORTB-1:0]    cand_sort, run_sort;
  logic                cand_wins;
  logic [MXKEYBX-1:0]  key_full, key_corr;
  logic [1:0]          sub_lsb;

  // Enable of the group currently on the mux; padded so index 7 reads 0.
  assign en_pad     = 8'(bus.grp_en);
  assign grp_en_cur = en_pad[grp_sel_q];

  // Sort keys of the incoming group and the running best.
`ifdef CCLUT_SORT_QLT_EN
  assign cand_sort = {bus.grp_pat, bus.grp_qlt};
  assign run_sort  = {run_pat_q, run_qlt_q};
`else
  assign cand_sort = bus.grp_pat;
  assign run_sort  = run_pat_q;
`endif

  // Strictly greater only: ties keep the earlier (lower-index) group.
  assign cand_wins = grp_en_cur && (cand_sort > run_sort);

  // ccLUT key correction; modulo-256 wrap below zero is intended.
  assign key_full = {run_grp_q, run_key_q};
  assign key_corr = key_full
                  + MXKEYBX'(run_offs_q[3:2])
                  + MXKEYBX'(run_offs_q[1] & run_offs_q[0])
                  - MXKEYBX'(2);
  assign sub_lsb  = 2'(run_offs_q[1:0] + 2'd1);

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      grp_sel_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      run_pat_q     <= '0;
      run_grp_q     <= '0;
      run_key_q     <= '0;
      run_offs_q    <= '0;
      run_qlt_q     <= '0;
      run_bend_q    <= '0;
      run_carry_q   <= '0;
      best_vld_q    <= 1'b0;
      best_pat_q    <= '0;
      best_qlt_q    <= '0;
      best_bend_q   <= '0;
      best_carry_q  <= '0;
      best_key_q    <= '0;
      best_subkey_q <= '0;
    end else begin
      state         <= state_nxt;
      grp_sel_q     <= grp_sel_nxt;
      busy_q        <= busy_nxt;
      done_q        <= done_nxt;
      run_pat_q     <= run_pat_nxt;
      run_grp_q     <= run_grp_nxt;
      run_key_q     <= run_key_nxt;
      run_offs_q    <= run_offs_nxt;
      run_qlt_q     <= run_qlt_nxt;
      run_bend_q    <= run_bend_nxt;
      run_carry_q   <= run_carry_nxt;
      best_vld_q    <= best_vld_nxt;
      best_pat_q    <= best_pat_nxt;
      best_qlt_q    <= best_qlt_nxt;
      best_bend_q   <= best_bend_nxt;
      best_carry_q  <= best_carry_nxt;
      best_key_q    <= best_key_nxt;
      best_subkey_q <= best_subkey_nxt;
    end
  end

  // Next-state, scan and result logic.
  always_comb begin
    state_nxt       = state;
    grp_sel_nxt     = grp_sel_q;
    busy_nxt        = busy_q;
    done_nxt        = 1'b0;
    run_pat_nxt     = run_pat_q;
    run_grp_nxt     = run_grp_q;
    run_key_nxt     = run_key_q;
    run_offs_nxt    = run_offs_q;
    run_qlt_nxt     = run_qlt_q;
    run_bend_nxt    = run_bend_q;
    run_carry_nxt   = run_carry_q;
    best_vld_nxt    = best_vld_q;
    best_pat_nxt    = best_pat_q;
    best_qlt_nxt    = best_qlt_q;
    best_bend_nxt   = best_bend_q;
    best_carry_nxt  = best_carry_q;
    best_key_nxt    = best_key_q;
    best_subkey_nxt = best_subkey_q;

    unique case (state)
      S_IDLE: begin
        grp_sel_nxt = '0;
        busy_nxt    = 1'b0;
        if (bus.start) begin
          state_nxt = S_SCAN;
          busy_nxt  = 1'b1;
        end
      end

      S_SCAN: begin
        // Group 0 seeds the running best unconditionally (zeros if disabled).
        if (grp_sel_q == 3'd0) begin
          run_grp_nxt   = 3'd0;
          run_pat_nxt   = grp_en_cur ? bus.grp_pat   : '0;
          run_key_nxt   = grp_en_cur ? bus.grp_key   : '0;
          run_offs_nxt  = grp_en_cur ? bus.grp_offs  : '0;
          run_qlt_nxt   = grp_en_cur ? bus.grp_qlt   : '0;
          run_bend_nxt  = grp_en_cur ? bus.grp_bend  : '0;
          run_carry_nxt = grp_en_cur ? bus.grp_carry : '0;
        end else if (cand_wins) begin
          run_grp_nxt   = grp_sel_q;
          run_pat_nxt   = bus.grp_pat;
          run_key_nxt   = bus.grp_key;
          run_offs_nxt  = bus.grp_offs;
          run_qlt_nxt   = bus.grp_qlt;
          run_bend_nxt  = bus.grp_bend;
          run_carry_nxt = bus.grp_carry;
        end
        if (grp_sel_q == LAST_GRP) begin
          state_nxt   = S_CALC;
          grp_sel_nxt = '0;
        end else begin
          grp_sel_nxt = 3'(grp_sel_q + 3'd1);
        end
      end

      S_CALC: begin
        best_pat_nxt    = run_pat_q;
        best_qlt_nxt    = run_qlt_q;
        best_bend_nxt   = run_bend_q;
        best_carry_nxt  = run_carry_q;
        best_key_nxt    = key_corr;
        best_subkey_nxt = {key_corr, sub_lsb};
        best_vld_nxt    = (run_pat_q >= bus.pat_thresh) && (run_pat_q != '0);
        done_nxt        = 1'b1;
        state_nxt       = S_DONE;
      end

      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt   = S_IDLE;
        busy_nxt    = 1'b0;
        grp_sel_nxt = '0;
      end
    endcase
  end

  assign bus.grp_sel     = grp_sel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.best_vld    = best_vld_q;
  assign bus.best_pat    = best_pat_q;
  assign bus.best_qlt    = best_qlt_q;
  assign bus.best_bend   = best_bend_q;
  assign bus.best_carry  = best_carry_q;
  assign bus.best_key    = best_key_q;
  assign bus.best_subkey = best_subkey_q;

endmodule

// File: tb/tb_clct_sort_seq_cclut.sv
// Scoreboard bench for clct_sort_seq_cclut: directed scans push their
// expected result (including the cycle done must appear in) into a queue;
// a negedge monitor pops and compares on every done pulse.
module tb_clct_sort_seq_cclut;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  clct_sort_seq_cclut_if bus ();

  clct_sort_seq_cclut dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int unsigned done_cyc;
    logic        vld;
    logic [6:0]  pat;
    logic [8:0]  qlt;
    logic [4:0]  bend;
    logic [11:0] carry;
    logic [7:0]  key;
    logic [9:0]  subkey;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  // Per-group source tables driving the external input mux.
  logic [6:0]  pat_tab   [8];
  logic [4:0]  key_tab   [8];
  logic [3:0]  offs_tab  [8];
  logic [8:0]  qlt_tab   [8];
  logic [4:0]  bend_tab  [8];
  logic [11:0] carry_tab [8];

  always_comb begin
    bus.grp_pat   = pat_tab[bus.grp_sel];
    bus.grp_key   = key_tab[bus.grp_sel];
    bus.grp_offs  = offs_tab[bus.grp_sel];
    bus.grp_qlt   = qlt_tab[bus.grp_sel];
    bus.grp_bend  = bend_tab[bus.grp_sel];
    bus.grp_carry = carry_tab[bus.grp_sel];
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        check("best_pat",   32'(bus.best_pat), 32'(e.pat));
        check("best_vld",   32'(bus.best_vld), 32'(e.vld));
        check("best_key",   32'(bus.best_key), 32'(e.key));
        check("best_subkey", 32'(bus.best_subkey), 32'(e.subkey));
        check("best_qlt",   32'(bus.best_qlt), 32'(e.qlt));
        check("best_bend",  32'(bus.best_bend), 32'(e.bend));
        check("best_carry", 32'(bus.best_carry), 32'(e.carry));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_defaults();
    for (int n = 0; n < 8; n++) begin
      pat_tab[n]   = '0;
      key_tab[n]   = 5'(n + 3);
      offs_tab[n]  = '0;
      qlt_tab[n]   = 9'(10 + n);
      bend_tab[n]  = 5'(n + 1);
      carry_tab[n] = 12'(100 + n);
    end
    bus.grp_en     = 7'h7f;
    bus.pat_thresh = 7'd1;
  endtask

  // Pulse start before the next edge (E0); done must show 9 edges after now.
  task automatic run_scan(input logic vld, input logic [6:0] pat, input logic [8:0] qlt,
                          input logic [4:0] bend, input logic [11:0] carry,
                          input logic [7:0] key, input logic [9:0] subkey);
    exp_t e;
    e.done_cyc = cyc + 9;
    e.vld = vld; e.pat = pat; e.qlt = qlt; e.bend = bend;
    e.carry = carry; e.key = key; e.subkey = subkey;
    sb_q.push_back(e);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    tick();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},     32'(bus.busy), 32'd0);
    check({tag, "_done"},     32'(bus.done), 32'd0);
    check({tag, "_grp_sel"},  32'(bus.grp_sel), 32'd0);
    check({tag, "_best_vld"}, 32'(bus.best_vld), 32'd0);
    check({tag, "_best_pat"}, 32'(bus.best_pat), 32'd0);
    check({tag, "_best_key"}, 32'(bus.best_key), 32'd0);
    check({tag, "_best_subkey"}, 32'(bus.best_subkey), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    set_defaults();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_idle_zero("reset");

    // T1: lone pattern in group 3; {3,10}=106, +1 +1 -2 = 106; offs 3+1 wraps to 0.
    set_defaults();
    pat_tab[3] = 7'd5; key_tab[3] = 5'd10; offs_tab[3] = 4'b0111;
    run_scan(1'b1, 7'd5, 9'd13, 5'd4, 12'd103, 8'd106, {8'd106, 2'b00});
    for (int i = 0; i < 3; i++) tick();
    check("scan_busy", 32'(bus.busy), 32'd1);
    check("scan_grp_sel", 32'(bus.grp_sel), 32'd3);
    drain("t1_drain");
    check("idle_grp_sel", 32'(bus.grp_sel), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // T2: all pattern 6; group 0 (key 3 -> 1) wins, or group 4 when quality sorts.
    set_defaults();
    for (int n = 0; n < 7; n++) pat_tab[n] = 7'd6;
    qlt_tab[4] = 9'd200;
`ifdef CCLUT_SORT_QLT_EN
    run_scan(1'b1, 7'd6, 9'd200, 5'd5, 12'd104, 8'd133, {8'd133, 2'b01});
`else
    run_scan(1'b1, 7'd6, 9'd10, 5'd1, 12'd100, 8'd1, {8'd1, 2'b01});
`endif
    drain("t2_drain");

    // T3: disabled group 6 holds the highest pattern and is ignored.
    set_defaults();
    bus.grp_en = 7'b0111111;
    for (int n = 0; n < 7; n++) begin
      pat_tab[n] = 7'd2;
      qlt_tab[n] = 9'd20;
    end
    pat_tab[6] = 7'd7;
    run_scan(1'b1, 7'd2, 9'd20, 5'd1, 12'd100, 8'd1, {8'd1, 2'b01});
    drain("t3_drain");

    // T4: key underflow wraps to 254.
    set_defaults();
    bus.grp_en = 7'b0000001;
    for (int n = 1; n < 7; n++) pat_tab[n] = 7'd7;
    pat_tab[0] = 7'd3; key_tab[0] = 5'd0; offs_tab[0] = 4'd0;
    run_scan(1'b1, 7'd3, 9'd10, 5'd1, 12'd100, 8'd254, {8'd254, 2'b01});
    drain("t4_drain");

    // T7: every group disabled -> zero best, key still corrected.
    set_defaults();
    bus.grp_en = 7'b0000000;
    for (int n = 0; n < 7; n++) pat_tab[n] = 7'd7;
    run_scan(1'b0, 7'd0, 9'd0, 5'd0, 12'd0, 8'd254, {8'd254, 2'b01});
    drain("t7_drain");

    // T5: extra start during SCAN, then reset at E4 aborts without done.
    set_defaults();
    pat_tab[3] = 7'd5; key_tab[3] = 5'd10; offs_tab[3] = 4'b0111;
    bus.start = 1'b1;
    tick();                       // E0
    bus.start = 1'b0;
    tick();                       // E1
    bus.start = 1'b1;
    tick();                       // E2, ignored start
    bus.start = 1'b0;
    tick();                       // E3
    reset = 1'b1;
    tick();                       // E4 takes reset
    reset = 1'b0;
    check_idle_zero("abort");
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_done_q", 32'(sb_q.size()), 32'd0);
    run_scan(1'b1, 7'd5, 9'd13, 5'd4, 12'd103, 8'd106, {8'd106, 2'b00});
    drain("t5_drain");

    // T6: below threshold; starts in SCAN and DONE ignored, next IDLE start taken.
    set_defaults();
    bus.pat_thresh = 7'd3;
    for (int n = 0; n < 7; n++) begin
      pat_tab[n] = 7'd2;
      qlt_tab[n] = 9'd20;
    end
    run_scan(1'b0, 7'd2, 9'd20, 5'd1, 12'd100, 8'd1, {8'd1, 2'b01});   // now k+1
    repeat (4) tick();            // k+5
    bus.start = 1'b1;
    tick();                       // sampled in SCAN
    bus.start = 1'b0;
    repeat (3) tick();            // k+9, state DONE until next edge
    bus.start = 1'b1;
    tick();                       // sampled in DONE: ignored
    run_scan(1'b0, 7'd2, 9'd20, 5'd1, 12'd100, 8'd1, {8'd1, 2'b01});
    drain("t6_drain");
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got %0d required %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
